// File: rtl/pc_sequencer_pkg.sv
// Shared types and constants for the PC sequencer: FSM state encoding, default
// widths and the power-on contents of the branch-target table.
package pc_sequencer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        HALT  = 2'd3
    } state_t;

    localparam int unsigned D_DEF  = 10;
    localparam int unsigned NT_DEF = 16;

    // Entries 0..3 come up as a small jump table; everything else is zero.
    function automatic int unsigned reset_entry(input int unsigned idx);
        case (idx)
            1:       return 11;
            2:       return 41;
            3:       return 99;
            default: return 0;
        endcase
    endfunction

endpackage

// File: rtl/branch_target_table.sv
// Branch-target table: one combinational read port, one synchronous write port,
// asynchronously reset to the package's power-on contents.
module branch_target_table
    import pc_sequencer_pkg::*;
#(
    parameter int unsigned D  = D_DEF,
    parameter int unsigned NT = NT_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we,
    input  logic [$clog2(NT)-1:0] waddr,
    input  logic [D-1:0]          wdata,
    input  logic [$clog2(NT)-1:0] raddr,
    output logic [D-1:0]          rdata
);

    logic [D-1:0] r_mem [NT];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NT; i++) begin
                r_mem[i] <= D'(reset_entry(i));
            end
        end else if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    // Read sees the pre-write value when reading the entry being written.
    assign rdata = r_mem[raddr];

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: IDLE/RUN/FLUSH/HALT control with stall, halt and
// table-driven absolute or relative branches.
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter int unsigned D  = D_DEF,
    parameter int unsigned NT = NT_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  stall,
    input  logic                  halt_req,
    input  logic                  br_req,
    input  logic [$clog2(NT)-1:0] br_idx,
    input  logic                  br_rel,
    input  logic                  cfg_we,
    input  logic [$clog2(NT)-1:0] cfg_addr,
    input  logic [D-1:0]          cfg_data,
    output logic [D-1:0]          pc,
    output logic                  pc_valid,
    output logic                  halted,
    output logic                  br_taken,
    output logic                  cfg_err
);

    state_t       r_state;
    state_t       w_state_nxt;
    logic [D-1:0] r_pc;
    logic [D-1:0] w_pc_nxt;
    logic         r_br_taken;
    logic         w_br_taken_nxt;
    logic         r_cfg_err;
    logic         w_cfg_open;
    logic         w_tbl_we;
    logic [D-1:0] w_entry;
    logic [D-1:0] w_target;

    assign w_cfg_open = (r_state == IDLE) || (r_state == HALT);
    assign w_tbl_we   = cfg_we && w_cfg_open;

    branch_target_table #(
        .D  (D),
        .NT (NT)
    ) u_table (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (w_tbl_we),
        .waddr (cfg_addr),
        .wdata (cfg_data),
        .raddr (br_idx),
        .rdata (w_entry)
    );

    // D-bit add wraps naturally, so a two's-complement entry acts as a signed offset.
    assign w_target = br_rel ? (r_pc + w_entry) : w_entry;

    always_comb begin
        w_state_nxt    = r_state;
        w_pc_nxt       = r_pc;
        w_br_taken_nxt = 1'b0;
        case (r_state)
            IDLE, HALT: begin
                if (start) begin
                    w_state_nxt = RUN;
                    w_pc_nxt    = '0;
                end
            end
            RUN: begin
                if (halt_req) begin
                    w_state_nxt = HALT;
                end else if (stall) begin
                    w_state_nxt = RUN;
                end else if (br_req) begin
                    w_state_nxt    = FLUSH;
                    w_pc_nxt       = w_target;
                    w_br_taken_nxt = 1'b1;
                end else begin
                    w_pc_nxt = r_pc + D'(1);
                end
            end
            FLUSH: begin
                w_state_nxt = halt_req ? HALT : RUN;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_pc       <= '0;
            r_br_taken <= 1'b0;
            r_cfg_err  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_pc       <= w_pc_nxt;
            r_br_taken <= w_br_taken_nxt;
            r_cfg_err  <= cfg_we && !w_cfg_open;
        end
    end

    assign pc       = r_pc;
    assign pc_valid = (r_state == RUN);
    assign halted   = (r_state == HALT);
    assign br_taken = r_br_taken;
    assign cfg_err  = r_cfg_err;

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter D, default 10, program counter width in bits.
REQ-002 Parameter NT, default 16, number of branch-target table entries; index width is log2(NT) = 4.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  single-cycle pulse; begins fetch from PC 0.
REQ-006 stall  input  1  level signal; holds the PC.
REQ-007 halt_req  input  1  single-cycle pulse; stops fetch.
REQ-008 br_req  input  1  branch taken this cycle.
REQ-009 br_idx  input  4  branch-target table index.
REQ-010 br_rel  input  1  1 selects a relative branch (PC plus entry); 0 selects an absolute branch (PC equals entry).
REQ-011 cfg_we  input  1  table write strobe.
REQ-012 cfg_addr  input  4  table write index.
REQ-013 cfg_data  input  D  table write data; two's-complement when used as a relative offset.
REQ-014 pc  output  D  current fetch address.
REQ-015 pc_valid  output  1  pc is a valid fetch this cycle.
REQ-016 halted  output  1  sequencer is in HALT.
REQ-017 br_taken  output  1  one-cycle pulse on the edge where a branch is applied.
REQ-018 cfg_err  output  1  one-cycle pulse when a cfg_we is rejected.

Function
REQ-019 The FSM SHALL have four states: IDLE, RUN, FLUSH and HALT; the reset state is IDLE.
REQ-020 In IDLE, start SHALL load pc=0 and move the FSM to RUN; all other inputs except cfg_we are ignored.
REQ-021 In RUN, requests SHALL be resolved in this priority order: halt_req, then stall, then br_req, then sequential increment.
REQ-022 In RUN, halt_req SHALL move the FSM to HALT and hold pc.
REQ-023 In RUN, stall without halt_req SHALL hold pc and hold the state; br_req in the same cycle is dropped, not queued.
REQ-024 In RUN, br_req with no stall and no halt_req SHALL load pc with the new target, assert br_taken for one cycle and move the FSM to FLUSH.
REQ-025 An absolute branch target SHALL equal table[br_idx].
REQ-026 A relative branch target SHALL equal (pc + table[br_idx]) mod 2^D; for example, pc=4 with entry 0x3FF gives 3.
REQ-027 The sequential increment SHALL be pc = (pc + 1) mod 2^D, wrapping from 2^D-1 to 0 with no flag.
REQ-028 FLUSH SHALL last exactly one cycle with pc_valid=0 and pc held, then return to RUN.
REQ-029 In FLUSH, halt_req SHALL take the FSM to HALT; stall and br_req SHALL be ignored.
REQ-030 pc_valid SHALL equal 1 exactly when the state is RUN.
REQ-031 halted SHALL equal 1 exactly when the state is HALT.
REQ-032 In HALT, start SHALL load pc=0 and move the FSM to RUN; all other inputs except cfg_we are ignored.
REQ-033 cfg_we SHALL be accepted only in IDLE or HALT.
REQ-034 cfg_we in RUN or FLUSH SHALL leave the table unchanged and pulse cfg_err for one cycle.
REQ-035 A table write SHALL take effect on the next edge; a read of the same entry in the same cycle returns the old value.
REQ-036 br_idx and cfg_addr SHALL index all 16 entries, with no out-of-range case.

Reset
REQ-037 Asserting rst_n low at any time, including mid-branch or in FLUSH, SHALL immediately force state=IDLE, pc=0, pc_valid=0, halted=0, br_taken=0 and cfg_err=0.
REQ-038 Reset SHALL load table entries 0..3 with 0, 11, 41 and 99, and all other entries with 0.
REQ-039 After release of rst_n, the first accepted start SHALL fetch pc=0.

Structure
REQ-040 A shared package SHALL hold the state enum (IDLE, RUN, FLUSH, HALT), the default D and NT values, and the reset table contents.
REQ-041 The table SHALL be a separate sub-module, branch_target_table, with one combinational read port, one synchronous write port and asynchronous reset; the FSM and PC arithmetic stay in pc_sequencer.

Verification
REQ-042 Reset, then start, then 5 cycles with no requests -> pc reads 0,1,2,3,4 with pc_valid=1 throughout.
REQ-043 At pc=4, br_req with br_idx=2 and br_rel=0 -> br_taken pulses; next cycle pc=41 with pc_valid=0 (FLUSH); the cycle after pc=41 with pc_valid=1; then pc=42.
REQ-044 In HALT, write cfg_addr=5 with cfg_data=0x3FB; start; at pc=20, relative branch on idx 5 -> pc=15 (20 minus 5, mod 1024).
REQ-045 In RUN, assert stall and br_req together for 2 cycles -> pc is held and no br_taken; after stall drops, pc increments; a cfg_we during RUN pulses cfg_err and leaves the entry unchanged on read-back.
REQ-046 Force pc to 1023 in RUN -> next pc=0; in the same sequence, halt_req and br_req together -> HALT entered, br_taken=0.
REQ-047 rst_n low during FLUSH -> state=IDLE and pc=0 immediately; entry 1 reads back 11 after reset.
